ibex_efpga_ctrl: RTL and testbench

Parametrised eFPGA coprocessor controller that sits between the ibex EX stage and the embedded FPGA fabric. It replaces the fixed 32-bit, three-result, delay-only handshake with configurable widths, configurable result-channel count and two completion modes: fixed latency, or done-handshake with a timeout. It also adds a flush path and an error response. It registers operands toward the fabric and issues a one-cycle write strobe. It then returns a registered result, a one-cycle valid pulse and `ready_o` for the EX stage.

---
 rtl/ibex_efpga_pkg.sv | 30 +++
 rtl/ibex_efpga_timer.sv | 46 ++++
 rtl/ibex_efpga_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ibex_efpga_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_efpga_pkg.sv
// ibex_efpga_pkg
// Shared types for the eFPGA coprocessor controller:
//   - efpga_state_e   : controller FSM states
//   - efpga_mode_e    : completion mode (done handshake or fixed latency)
//   - efpga_cnt_width : counter width able to hold both the timeout span
//                       and any fixed-latency value
package ibex_efpga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } efpga_state_e;

   typedef enum logic {
      MODE_DONE  = 1'b0,
      MODE_FIXED = 1'b1
   } efpga_mode_e;

   function automatic int unsigned efpga_cnt_width(input int unsigned timeout_cycles,
                                                    input int unsigned delay_width);
      int unsigned span_timeout;
      int unsigned span_delay;
      span_timeout = timeout_cycles + 1;
      span_delay   = 32'd1 << delay_width;
      return (span_timeout > span_delay) ? $clog2(span_timeout) : $clog2(span_delay);
   endfunction

endpackage

// File: rtl/ibex_efpga_timer.sv
// ibex_efpga_timer
// Loadable up/down counter with a terminal-count compare, shared by the
// fixed-latency (count down) and done/timeout (count up) completion modes.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       load load_val_i (has priority over counting)
//   load_val_i   value to load
//   cnt_en_i     count one step this cycle
//   up_i         1 = increment, 0 = decrement
//   tc_val_i     terminal value to compare against
//   tc_o         counter currently equals tc_val_i
module ibex_efpga_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             cnt_en_i,
   input  logic             up_i,
   input  logic [CNT_W-1:0] tc_val_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_en_i) begin
         cnt_d = up_i ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/ibex_efpga_ctrl.sv
// ibex_efpga_ctrl
// Controller between the ibex EX stage and the embedded FPGA fabric.
// Captures a request, launches it with a one-cycle strobe, waits either a
// fixed number of cycles or for the fabric done (bounded by a timeout), and
// returns a registered result with a one-cycle valid/ready pulse.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   en_i, operator_i,
//   operand_a_i, operand_b_i,
//   delay_i                     EX request (delay 0 = done mode)
//   flush_i                     abort any in-flight operation
//   ready_o, valid_o, err_o,
//   result_o                    response to EX
//   busy_o                      controller not idle (clock-gate enable)
//   efpga_operand_a_o/_b_o,
//   efpga_operator_o,
//   efpga_write_strobe_o        registered request toward the fabric
//   efpga_result_i              NUM_RESULTS packed result channels
//   efpga_done_i                fabric completion (done mode only)
module ibex_efpga_ctrl
   import ibex_efpga_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_RESULTS    = 3,
   parameter int unsigned OP_WIDTH       = 2,
   parameter int unsigned DELAY_WIDTH    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              en_i,
   input  logic [OP_WIDTH-1:0]               operator_i,
   input  logic [DATA_WIDTH-1:0]             operand_a_i,
   input  logic [DATA_WIDTH-1:0]             operand_b_i,
   input  logic [DELAY_WIDTH-1:0]            delay_i,
   input  logic                              flush_i,
   output logic                              ready_o,
   output logic                              valid_o,
   output logic                              err_o,
   output logic [DATA_WIDTH-1:0]             result_o,
   output logic                              busy_o,
   output logic [DATA_WIDTH-1:0]             efpga_operand_a_o,
   output logic [DATA_WIDTH-1:0]             efpga_operand_b_o,
   output logic [OP_WIDTH-1:0]               efpga_operator_o,
   output logic                              efpga_write_strobe_o,
   input  logic [NUM_RESULTS*DATA_WIDTH-1:0] efpga_result_i,
   input  logic                              efpga_done_i
);

   localparam int unsigned CNT_W = efpga_cnt_width(TIMEOUT_CYCLES, DELAY_WIDTH);
   // Widened by one bit so NUM_RESULTS == 2**OP_WIDTH is representable.
   localparam logic [OP_WIDTH:0] NUM_RES = (OP_WIDTH+1)'(NUM_RESULTS);

   efpga_state_e               state_q, state_d;
   logic [DATA_WIDTH-1:0]      a_q, b_q;
   logic [OP_WIDTH-1:0]        op_q;
   logic [DELAY_WIDTH-1:0]     delay_q;
   logic                       strobe_q;
   logic [DATA_WIDTH-1:0]      result_q, result_d;
   logic                       err_q, err_d;
   logic                       capture;
   logic                       op_illegal;
   efpga_mode_e                mode;
   logic [DATA_WIDTH-1:0]      sel_result;
   logic                       tmr_load, tmr_en, tmr_tc;
   logic [CNT_W-1:0]           tmr_load_val, tmr_tc_val;

   assign op_illegal = ({1'b0, operator_i} >= NUM_RES);
   assign mode       = (delay_q == '0) ? MODE_DONE : MODE_FIXED;

   // Result channel selected by the captured operator.
   always_comb begin
      sel_result = '0;
      for (int k = 0; k < int'(NUM_RESULTS); k++) begin
         if (op_q == OP_WIDTH'(k)) begin
            sel_result = efpga_result_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Fixed mode counts D down to 1 (D WAIT cycles); done mode counts up
   // from 0 and expires on the TIMEOUT_CYCLES-th WAIT cycle.
   assign tmr_load_val = (mode == MODE_FIXED) ? CNT_W'(delay_q) : '0;
   assign tmr_tc_val   = (mode == MODE_FIXED) ? CNT_W'(1) : CNT_W'(TIMEOUT_CYCLES - 1);

   ibex_efpga_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .cnt_en_i   (tmr_en),
      .up_i       (mode == MODE_DONE),
      .tc_val_i   (tmr_tc_val),
      .tc_o       (tmr_tc)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      err_d    = err_q;
      capture  = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (en_i) begin
               capture = 1'b1;
               if (op_illegal) begin
                  state_d  = ST_RESP;
                  err_d    = 1'b1;
                  result_d = '0;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            tmr_load = 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            tmr_en = 1'b1;
            if (mode == MODE_FIXED) begin
               if (tmr_tc) begin
                  state_d  = ST_RESP;
                  result_d = sel_result;
                  err_d    = 1'b0;
               end
            end else if (efpga_done_i) begin
               // done beats a coincident timeout
               state_d  = ST_RESP;
               result_d = sel_result;
               err_d    = 1'b0;
            end else if (tmr_tc) begin
               state_d  = ST_RESP;
               result_d = '0;
               err_d    = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort leaves the response registers untouched.
      if (flush_i && (state_q != ST_IDLE)) begin
         state_d  = ST_IDLE;
         result_d = result_q;
         err_d    = err_q;
         tmr_load = 1'b0;
         tmr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         delay_q  <= '0;
         strobe_q <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         strobe_q <= (state_d == ST_ISSUE);
         result_q <= result_d;
         err_q    <= err_d;
         if (capture) begin
            a_q     <= operand_a_i;
            b_q     <= operand_b_i;
            op_q    <= operator_i;
            delay_q <= delay_i;
         end
      end
   end

   assign valid_o              = (state_q == ST_RESP) & ~flush_i;
   assign ready_o              = valid_o;
   assign busy_o               = (state_q != ST_IDLE);
   assign err_o                = err_q;
   assign result_o             = result_q;
   assign efpga_operand_a_o    = a_q;
   assign efpga_operand_b_o    = b_q;
   assign efpga_operator_o     = op_q;
   assign efpga_write_strobe_o = strobe_q;

endmodule

// File: tb/tb_ibex_efpga_ctrl.sv
// tb_ibex_efpga_ctrl
// Directed bench for ibex_efpga_ctrl with a cycle-number based reference
// model (launch cycle + latency arithmetic) checked every cycle, plus
// hand-computed latency/result expectations per scenario.
module tb_ibex_efpga_ctrl;

   localparam int DW   = 32;
   localparam int NRES = 3;
   localparam int OPW  = 2;
   localparam int DLW  = 4;
   localparam int TMO  = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en_i = 1'b0;
   logic [OPW-1:0]  operator_i = '0;
   logic [DW-1:0]   operand_a_i = '0, operand_b_i = '0;
   logic [DLW-1:0]  delay_i = '0;
   logic            flush_i = 1'b0;
   logic            ready_o, valid_o, err_o, busy_o, efpga_write_strobe_o;
   logic [DW-1:0]   result_o, efpga_operand_a_o, efpga_operand_b_o;
   logic [OPW-1:0]  efpga_operator_o;
   logic [NRES*DW-1:0] efpga_result_i;
   logic            efpga_done_i = 1'b0;

   logic [DW-1:0] chv [NRES];
   initial begin
      chv[0] = 32'h1111_0000;
      chv[1] = 32'hDEAD_BEEF;
      chv[2] = 32'hCAFE_F00D;
   end
   assign efpga_result_i = {chv[2], chv[1], chv[0]};

   always #5 clk = ~clk;

   ibex_efpga_ctrl #(
      .DATA_WIDTH(DW), .NUM_RESULTS(NRES), .OP_WIDTH(OPW),
      .DELAY_WIDTH(DLW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .operator_i(operator_i),
      .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .delay_i(delay_i),
      .flush_i(flush_i), .ready_o(ready_o), .valid_o(valid_o), .err_o(err_o),
      .result_o(result_o), .busy_o(busy_o),
      .efpga_operand_a_o(efpga_operand_a_o), .efpga_operand_b_o(efpga_operand_b_o),
      .efpga_operator_o(efpga_operator_o), .efpga_write_strobe_o(efpga_write_strobe_o),
      .efpga_result_i(efpga_result_i), .efpga_done_i(efpga_done_i)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // An operation is described by its launch cycle (the cycle en_i is taken
   // while idle) and its response cycle; everything else follows from them.
   int            cyc = 0;
   bit            m_in = 0;      // operation in flight during cycle cyc
   int            m_launch = 0;
   int            m_resp = -1;   // -1: not yet known (done mode)
   bit            m_legal = 0;
   bit            m_done_mode = 0;
   logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;
   logic [OPW-1:0] m_op = '0;
   logic          m_err = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_in = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_err = 1'b0;
            m_legal = 0; m_resp = -1;
         end else begin
            if (m_in) begin
               if (flush_i) begin
                  m_in = 0;
               end else if (cyc == m_resp) begin
                  m_in = 0;
               end else if (m_done_mode) begin
                  if (m_resp < 0 && cyc >= m_launch + 2) begin
                     if (efpga_done_i) begin
                        m_resp = cyc + 1; m_res = chv[m_op]; m_err = 1'b0;
                     end else if (cyc == m_launch + 1 + TMO) begin
                        m_resp = cyc + 1; m_res = '0; m_err = 1'b1;
                     end
                  end
               end else if (m_legal && cyc == m_resp - 1) begin
                  m_res = chv[m_op]; m_err = 1'b0;
               end
            end else if (en_i) begin
               m_in = 1; m_launch = cyc;
               m_a = operand_a_i; m_b = operand_b_i; m_op = operator_i;
               m_legal = (int'(operator_i) < NRES);
               if (!m_legal) begin
                  m_resp = cyc + 1; m_err = 1'b1; m_done_mode = 0;
               end else if (delay_i == 0) begin
                  m_done_mode = 1; m_resp = -1;
               end else begin
                  m_done_mode = 0; m_resp = cyc + 2 + int'(delay_i);
               end
            end
            cyc++;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         begin
            bit ev;
            ev = m_in && (cyc == m_resp) && !flush_i;
            chk("busy", busy_o, m_in);
            chk("strobe", efpga_write_strobe_o, m_in && m_legal && (cyc == m_launch + 1));
            chk("valid", valid_o, ev);
            chk("ready", ready_o, ev);
            chk("opa", efpga_operand_a_o, m_a);
            chk("opb", efpga_operand_b_o, m_b);
            chk("op", efpga_operator_o, m_op);
            if (ev) begin
               chk("err", err_o, m_err);
               if (m_legal) chk("result", result_o, m_res);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Holds en_i from cycle k=0 until the n_req-th ready; done_i pulses dn
   // cycles after the most recent strobe; flush_i pulses in cycle fl_k.
   task automatic run(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DLW-1:0] d, input int dn, input int fl_k, input int n_req,
                      output int s0, output int s1, output int r0, output int r1, output int ns,
                      output logic [DW-1:0] res, output logic er);
      int nr;
      int last_s;
      s0 = -1; s1 = -1; r0 = -1; r1 = -1; ns = 0; nr = 0; last_s = -1;
      res = '0; er = 1'b0;
      @(posedge clk); #1;
      en_i = 1'b1; operator_i = op; operand_a_i = a; operand_b_i = b; delay_i = d;
      for (int k = 0; k < 60; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         efpga_done_i = (dn >= 0 && last_s >= 0 && k == last_s + dn);
         flush_i      = (k == fl_k);
         @(negedge clk);
         if (efpga_write_strobe_o) begin
            if (ns == 0) s0 = k; else s1 = k;
            ns++; last_s = k;
         end
         if (ready_o) begin
            if (nr == 0) r0 = k; else r1 = k;
            nr++; res = result_o; er = err_o;
            if (nr == n_req) break;
         end
      end
      @(posedge clk); #1;
      en_i = 1'b0; efpga_done_i = 1'b0; flush_i = 1'b0;
      chk("response_within_budget", nr, n_req);
   endtask

   initial begin
      int s0, s1, r0, r1, ns;
      logic [DW-1:0] res;
      logic er;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_strobe", efpga_write_strobe_o, 0);
      rst_n = 1'b1;

      // fixed latency D=3, channel 1
      run(2'd1, 32'hA5A5_0001, 32'h5A5A_0001, 4'd3, -1, -1, 1, s0, s1, r0, r1, ns, res, er);
      chk("fix3_strobe_cyc", s0, 1);  chk("fix3_lat", r0, 5);
      chk("fix3_res", res, 32'hDEAD_BEEF); chk("fix3_err", er, 0); chk("fix3_nstrobe", ns, 1);

      // fixed latency extremes
      run(2'd2, 32'h1, 32'h2, 4'd1, -1, -1, 1, s0, s1, r0, r1, ns, res, er);
      chk("fix1_lat", r0, 3); chk("fix1_res", res, 32'hCAFE_F00D);
      run(2'd0, 32'h3, 32'h4, 4'd15, -1, -1, 1, s0, s1, r0, r1, ns, res, er);
      chk("fix15_lat", r0, 17); chk("fix15_res", res, 32'h1111_0000);

      // done mode: done 5 cycles after strobe
      run(2'd2, 32'h10, 32'h20, 4'd0, 5, -1, 1, s0, s1, r0, r1, ns, res, er);
      chk("done5_lat", r0, 7); chk("done5_res", res, 32'hCAFE_F00D); chk("done5_err", er, 0);

      // done mode: done in the first WAIT cycle
      run(2'd1, 32'h11, 32'h21, 4'd0, 1, -1, 1, s0, s1, r0, r1, ns, res, er);
      chk("done1_lat", r0, 3); chk("done1_res", res, 32'hDEAD_BEEF);

      // timeout
      run(2'd0, 32'h12, 32'h22, 4'd0, -1, -1, 1, s0, s1, r0, r1, ns, res, er);
      chk("tmo_lat", r0, 10); chk("tmo_err", er, 1); chk("tmo_res", res, 0);

      // done coincident with timeout
      run(2'd2, 32'h13, 32'h23, 4'd0, 8, -1, 1, s0, s1, r0, r1, ns, res, er);
      chk("coin_lat", r0, 10); chk("coin_err", er, 0); chk("coin_res", res, 32'hCAFE_F00D);

      // illegal operator
      run(2'd3, 32'h14, 32'h24, 4'd2, -1, -1, 1, s0, s1, r0, r1, ns, res, er);
      chk("ill_lat", r0, 1); chk("ill_err", er, 1); chk("ill_nstrobe", ns, 0);

      // flush in WAIT, en_i held: relaunch
      run(2'd1, 32'h15, 32'h25, 4'd4, -1, 3, 1, s0, s1, r0, r1, ns, res, er);
      chk("fl_s0", s0, 1); chk("fl_s1", s1, 5); chk("fl_lat", r0, 10);
      chk("fl_res", res, 32'hDEAD_BEEF);

      // back-to-back with en_i held
      run(2'd0, 32'h16, 32'h26, 4'd1, -1, -1, 2, s0, s1, r0, r1, ns, res, er);
      chk("b2b_r0", r0, 3); chk("b2b_s1_gap", s1 - r0, 2); chk("b2b_r1", r1, 7);

      // reset in WAIT
      @(posedge clk); #1;
      en_i = 1'b1; operator_i = 2'd1; operand_a_i = 32'hFFFF_0000;
      operand_b_i = 32'h0000_FFFF; delay_i = 4'd6;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy_o, 0); chk("mrst_valid", valid_o, 0);
      chk("mrst_result", result_o, 0); chk("mrst_err", err_o, 0);
      chk("mrst_opa", efpga_operand_a_o, 0); chk("mrst_op", efpga_operator_o, 0);
      chk("mrst_strobe", efpga_write_strobe_o, 0);
      en_i = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;

      run(2'd2, 32'h17, 32'h27, 4'd2, -1, -1, 1, s0, s1, r0, r1, ns, res, er);
      chk("post_rst_lat", r0, 4); chk("post_rst_res", res, 32'hCAFE_F00D);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
